l2_cache_controller: RTL and testbench

//  Control FSM for the unified L2 cache. Sits directly downstream of the I/D arbiter:
//  - consumes the arbiter's muxed mem_read/mem_write request.
//  - returns mem_resp, which is the arbiter's l2_resp.

---
 rtl/l2_cache_controller.sv | 169 ++++++++++++++++
 tb/tb_l2_cache_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_cache_controller.sv
// Control FSM for the unified L2 cache: hit handling, dirty write-back and line fill sequencing.
// Optional performance counters are enabled by defining L2_PERF_CNT_EN.
module l2_cache_controller #(
    parameter int WAYS  = 2,
    parameter int CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mem_read,
    input  logic                    mem_write,
    output logic                    mem_resp,
    input  logic [WAYS-1:0]         way_hit,
    input  logic [$clog2(WAYS)-1:0] lru_way,
    input  logic                    victim_dirty,
    output logic [WAYS-1:0]         load_way,
    output logic                    load_data,
    output logic                    load_tag,
    output logic                    set_dirty,
    output logic                    clear_dirty,
    output logic                    lru_update,
    output logic                    data_in_sel,
    output logic                    pmem_addr_sel,
    output logic                    pmem_read,
    output logic                    pmem_write,
    input  logic                    pmem_resp,
`ifdef L2_PERF_CNT_EN
    input  logic                    perf_clr,
    output logic [CNT_W-1:0]        hit_cnt,
    output logic [CNT_W-1:0]        miss_cnt,
    output logic [CNT_W-1:0]        wb_cnt,
`endif
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COMPARE   = 2'd1,
        S_WRITEBACK = 2'd2,
        S_ALLOCATE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic req;
    logic hit;

    assign req       = mem_read | mem_write;
    assign hit       = |way_hit;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs are decoded from the current state and live inputs; forced low while in reset.
    always_comb begin
        state_next    = state;
        mem_resp      = 1'b0;
        load_way      = '0;
        load_data     = 1'b0;
        load_tag      = 1'b0;
        set_dirty     = 1'b0;
        clear_dirty   = 1'b0;
        lru_update    = 1'b0;
        data_in_sel   = 1'b0;
        pmem_addr_sel = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        if (rst_n) begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        state_next = S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (!req) begin
                        state_next = S_IDLE;
                    end else if (hit) begin
                        mem_resp   = 1'b1;
                        lru_update = 1'b1;
                        load_way   = way_hit;
                        // mem_write wins when both request lines are high
                        if (mem_write) begin
                            load_data = 1'b1;
                            set_dirty = 1'b1;
                        end
                        state_next = S_IDLE;
                    end else if (victim_dirty) begin
                        state_next = S_WRITEBACK;
                    end else begin
                        state_next = S_ALLOCATE;
                    end
                end
                S_WRITEBACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                    if (pmem_resp) begin
                        state_next = S_ALLOCATE;
                    end
                end
                S_ALLOCATE: begin
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        load_way    = {{(WAYS-1){1'b0}}, 1'b1} << lru_way;
                        load_data   = 1'b1;
                        load_tag    = 1'b1;
                        clear_dirty = 1'b1;
                        data_in_sel = 1'b1;
                        state_next  = S_COMPARE;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

`ifdef L2_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic filled;
    logic miss_ev;
    logic wb_ev;

    assign miss_ev = (state == S_COMPARE) && req && !hit;
    assign wb_ev   = (state == S_WRITEBACK) && pmem_resp;

    // Remembers that the current request went through a fill, so its final resp is not a hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filled <= 1'b0;
        end else if (state == S_IDLE) begin
            filled <= 1'b0;
        end else if (miss_ev) begin
            filled <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else if (perf_clr) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            if (mem_resp && !filled && hit_cnt != CNT_MAX) begin
                hit_cnt <= hit_cnt + 1'b1;
            end
            if (miss_ev && miss_cnt != CNT_MAX) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
            if (wb_ev && wb_cnt != CNT_MAX) begin
                wb_cnt <= wb_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_l2_cache_controller.sv
// Directed bench for l2_cache_controller: hits, clean/dirty misses, aborts, reset and
// (with L2_PERF_CNT_EN) the performance counters.
module tb_l2_cache_controller;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CMP   = 2'd1;
    localparam logic [1:0] ST_WB    = 2'd2;
    localparam logic [1:0] ST_ALLOC = 2'd3;

    // Packed outputs: resp, load_way[1:0], load_data, load_tag, set_dirty, clear_dirty,
    // lru_update, data_in_sel, pmem_addr_sel, pmem_read, pmem_write
    localparam logic [11:0] ZERO   = 12'b0_00_0_0_0_0_0_0_0_0_0;
    localparam logic [11:0] RH01   = 12'b1_01_0_0_0_0_1_0_0_0_0;
    localparam logic [11:0] RH10   = 12'b1_10_0_0_0_0_1_0_0_0_0;
    localparam logic [11:0] WH01   = 12'b1_01_1_0_1_0_1_0_0_0_0;
    localparam logic [11:0] WH10   = 12'b1_10_1_0_1_0_1_0_0_0_0;
    localparam logic [11:0] PRD    = 12'b0_00_0_0_0_0_0_0_0_1_0;
    localparam logic [11:0] PWB    = 12'b0_00_0_0_0_0_0_0_1_0_1;
    localparam logic [11:0] FILL01 = 12'b0_01_1_1_0_1_0_1_0_1_0;
    localparam logic [11:0] FILL10 = 12'b0_10_1_1_0_1_0_1_0_1_0;

    logic       clk;
    logic       rst_n;
    logic       mem_read;
    logic       mem_write;
    logic       mem_resp;
    logic [1:0] way_hit;
    logic [0:0] lru_way;
    logic       victim_dirty;
    logic [1:0] load_way;
    logic       load_data;
    logic       load_tag;
    logic       set_dirty;
    logic       clear_dirty;
    logic       lru_update;
    logic       data_in_sel;
    logic       pmem_addr_sel;
    logic       pmem_read;
    logic       pmem_write;
    logic       pmem_resp;
    logic [1:0] dbg_state;
`ifdef L2_PERF_CNT_EN
    logic       perf_clr;
    logic [3:0] hit_cnt;
    logic [3:0] miss_cnt;
    logic [3:0] wb_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    l2_cache_controller #(
        .WAYS (2),
`ifdef L2_PERF_CNT_EN
        .CNT_W(4)
`else
        .CNT_W(32)
`endif
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_resp     (mem_resp),
        .way_hit      (way_hit),
        .lru_way      (lru_way),
        .victim_dirty (victim_dirty),
        .load_way     (load_way),
        .load_data    (load_data),
        .load_tag     (load_tag),
        .set_dirty    (set_dirty),
        .clear_dirty  (clear_dirty),
        .lru_update   (lru_update),
        .data_in_sel  (data_in_sel),
        .pmem_addr_sel(pmem_addr_sel),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_resp    (pmem_resp),
`ifdef L2_PERF_CNT_EN
        .perf_clr     (perf_clr),
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt),
        .wb_cnt       (wb_cnt),
`endif
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] outs();
        return {mem_resp, load_way, load_data, load_tag, set_dirty, clear_dirty,
                lru_update, data_in_sel, pmem_addr_sel, pmem_read, pmem_write};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs at negedge, then check outputs and state mid-cycle.
    task automatic step(input logic rd, input logic wr, input logic [1:0] hit,
                        input logic lru, input logic vd, input logic presp,
                        input logic [11:0] exp_outs, input logic [1:0] exp_st,
                        input string tag);
        @(negedge clk);
        mem_read     = rd;
        mem_write    = wr;
        way_hit      = hit;
        lru_way      = lru;
        victim_dirty = vd;
        pmem_resp    = presp;
        #1;
        check_eq({tag, "_outs"}, 32'(outs()), 32'(exp_outs));
        check_eq({tag, "_st"}, 32'(dbg_state), 32'(exp_st));
        check_eq({tag, "_pmem_excl"}, 32'(pmem_read & pmem_write), 32'd0);
    endtask

    task automatic read_hit01(input string tag);
        step(1, 0, 2'b01, 0, 0, 0, ZERO, ST_IDLE, {tag, "_req"});
        step(1, 0, 2'b01, 0, 0, 0, RH01, ST_CMP, {tag, "_resp"});
    endtask

    task automatic dirty_miss(input string tag);
        step(1, 0, 2'b00, 0, 1, 0, ZERO, ST_IDLE, {tag, "_req"});
        step(1, 0, 2'b00, 0, 1, 0, ZERO, ST_CMP, {tag, "_cmp"});
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 2'b00, 0, 1, 0, PWB, ST_WB, {tag, "_wb"});
        end
        step(1, 0, 2'b00, 0, 1, 1, PWB, ST_WB, {tag, "_wbresp"});
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 2'b00, 0, 0, 0, PRD, ST_ALLOC, {tag, "_alloc"});
        end
        step(1, 0, 2'b00, 0, 0, 1, FILL01, ST_ALLOC, {tag, "_fill"});
        step(1, 0, 2'b01, 0, 0, 0, RH01, ST_CMP, {tag, "_resp"});
    endtask

    initial begin
        rst_n        = 1'b0;
        mem_read     = 1'b1;
        mem_write    = 1'b0;
        way_hit      = 2'b01;
        lru_way      = 1'b0;
        victim_dirty = 1'b0;
        pmem_resp    = 1'b0;
`ifdef L2_PERF_CNT_EN
        perf_clr     = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_eq("reset_outs", 32'(outs()), 32'(ZERO));
        check_eq("reset_st", 32'(dbg_state), 32'(ST_IDLE));
        mem_read = 1'b0;
        rst_n    = 1'b1;

        // read hit, way 0
        read_hit01("rh");
        step(0, 0, 2'b00, 0, 0, 0, ZERO, ST_IDLE, "rh_idle");

        // write hit, way 1
        step(0, 1, 2'b10, 0, 0, 0, ZERO, ST_IDLE, "wh_req");
        step(0, 1, 2'b10, 0, 0, 0, WH10, ST_CMP, "wh_resp");
        step(0, 0, 2'b00, 0, 0, 0, ZERO, ST_IDLE, "wh_idle");

        // read and write together behave as a write
        step(1, 1, 2'b01, 0, 0, 0, ZERO, ST_IDLE, "rw_req");
        step(1, 1, 2'b01, 0, 0, 0, WH01, ST_CMP, "rw_resp");

        // clean miss into way 1, fill after 5 cycles
        step(1, 0, 2'b00, 1, 0, 0, ZERO, ST_IDLE, "cm_req");
        step(1, 0, 2'b00, 1, 0, 0, ZERO, ST_CMP, "cm_cmp");
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 2'b00, 1, 0, 0, PRD, ST_ALLOC, "cm_alloc");
        end
        step(1, 0, 2'b00, 1, 0, 1, FILL10, ST_ALLOC, "cm_fill");
        step(1, 0, 2'b10, 1, 0, 0, RH10, ST_CMP, "cm_resp");
        step(0, 0, 2'b00, 0, 0, 0, ZERO, ST_IDLE, "cm_idle");

        // dirty miss: write-back then fill
        dirty_miss("dm");
        step(0, 0, 2'b00, 0, 0, 0, ZERO, ST_IDLE, "dm_idle");

        // requester withdraws during allocate
        step(1, 0, 2'b00, 0, 0, 0, ZERO, ST_IDLE, "ab_req");
        step(1, 0, 2'b00, 0, 0, 0, ZERO, ST_CMP, "ab_cmp");
        step(1, 0, 2'b00, 0, 0, 0, PRD, ST_ALLOC, "ab_alloc");
        step(0, 0, 2'b00, 0, 0, 0, PRD, ST_ALLOC, "ab_drop");
        step(0, 0, 2'b00, 0, 0, 0, PRD, ST_ALLOC, "ab_hold");
        step(0, 0, 2'b00, 0, 0, 1, FILL01, ST_ALLOC, "ab_fill");
        step(0, 0, 2'b01, 0, 0, 0, ZERO, ST_CMP, "ab_noresp");
        step(0, 0, 2'b00, 0, 0, 0, ZERO, ST_IDLE, "ab_idle");

        // stray pmem_resp in idle is ignored
        step(0, 0, 2'b00, 0, 0, 1, ZERO, ST_IDLE, "stray_resp");
        step(0, 0, 2'b00, 0, 0, 0, ZERO, ST_IDLE, "stray_after");

        // asynchronous reset in the middle of a write-back
        step(1, 0, 2'b00, 0, 1, 0, ZERO, ST_IDLE, "rst_req");
        step(1, 0, 2'b00, 0, 1, 0, ZERO, ST_CMP, "rst_cmp");
        step(1, 0, 2'b00, 0, 1, 0, PWB, ST_WB, "rst_wb");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_outs", 32'(outs()), 32'(ZERO));
        check_eq("rst_mid_st", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        rst_n    = 1'b1;
        mem_read = 1'b0;
        step(0, 0, 2'b00, 0, 0, 0, ZERO, ST_IDLE, "rst_after");

`ifdef L2_PERF_CNT_EN
        perf_clr = 1'b1;
        step(0, 0, 2'b00, 0, 0, 0, ZERO, ST_IDLE, "pc_clr");
        perf_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            read_hit01("pc_hit");
        end
        dirty_miss("pc_dm");
        step(0, 0, 2'b00, 0, 0, 0, ZERO, ST_IDLE, "pc_idle");
        check_eq("pc_hit_cnt", 32'(hit_cnt), 32'd3);
        check_eq("pc_miss_cnt", 32'(miss_cnt), 32'd1);
        check_eq("pc_wb_cnt", 32'(wb_cnt), 32'd1);

        // clear wins over a simultaneous hit
        step(1, 0, 2'b01, 0, 0, 0, ZERO, ST_IDLE, "pc_clrhit_req");
        perf_clr = 1'b1;
        step(1, 0, 2'b01, 0, 0, 0, RH01, ST_CMP, "pc_clrhit_resp");
        perf_clr = 1'b0;
        step(0, 0, 2'b00, 0, 0, 0, ZERO, ST_IDLE, "pc_clrhit_idle");
        check_eq("pc_clr_hit", 32'(hit_cnt), 32'd0);
        check_eq("pc_clr_miss", 32'(miss_cnt), 32'd0);
        check_eq("pc_clr_wb", 32'(wb_cnt), 32'd0);

        // 4-bit counter saturates
        for (int i = 0; i < 20; i++) begin
            read_hit01("pc_sat");
        end
        step(0, 0, 2'b00, 0, 0, 0, ZERO, ST_IDLE, "pc_sat_idle");
        check_eq("pc_sat_hit", 32'(hit_cnt), 32'd15);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
